hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised issue-hazard controller for the pipelined RISC-V core. It replaces the fixed load-use rule with a per-register latency scoreboard, so execution units of 0..MAX_LAT cycles can share one issue point. It sits between Decode and Execute and gates the Decode->Execute transfer. It also squashes the scoreboard entry of a flushed instruction, counts stall cycles, and exports the pending-register mask. Forwarding muxes stay in the existing forwarding block.

Parameters:
NUM_REGS, 32, number of architectural registers (x0 hard-wired zero, never tracked)
REG_ADDR_W, 5, register index width; must satisfy 2**REG_ADDR_W >= NUM_REGS
MAX_LAT, 4, largest result latency in cycles; any larger request is clamped to this
CNT_W, $clog2(MAX_LAT+1), width of each per-register countdown
PERF_W, 32, width of the stall performance counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous active-low reset
issue_valid_i  in  1  Decode holds an instruction ready to enter Execute
issue_rs1_i  in  REG_ADDR_W  source 1 index
issue_rs1_used_i  in  1  rs1 is read by the instruction
issue_rs2_i  in  REG_ADDR_W  source 2 index
issue_rs2_used_i  in  1  rs2 is read by the instruction
issue_rd_i  in  REG_ADDR_W  destination index
issue_rd_we_i  in  1  instruction writes rd
issue_lat_i  in  CNT_W  cycles until the result becomes forwardable (0 = ALU forward path)
flush_i  in  1  branch taken in Execute (PCSrcE); squashes the instruction issued in the previous cycle
issue_stall_o  out  1  combinational; hold the Fetch/Decode registers and insert a bubble into Execute
issue_fire_o  out  1  combinational; issue_valid_i & ~issue_stall_o & ~flush_i
pending_mask_o  out  NUM_REGS  registered; bit r = counter[r] != 0
stall_count_o  out  PERF_W  saturating count of stalled cycles

Behaviour:
- Reset (rst low, asynchronous): all counters = 0, last_valid = 0, last_rd = 0, stall_count_o = 0, pending_mask_o = 0. Reset mid-operation discards all pending entries immediately.
- Source hazard: src_haz = (rs1_used & rs1 != 0 & cnt[rs1] != 0) | (rs2_used & rs2 != 0 & cnt[rs2] != 0).
- WAW hazard: waw = rd_we & rd != 0 & cnt[rd] != 0. A register therefore never has two in-flight producers.
- issue_stall_o = issue_valid_i & (src_haz | waw). Hazard checks use the counter values from before the current edge.
- Each cycle, every nonzero counter decrements by 1. It saturates at 0 and never wraps.
- On fire with rd_we & rd != 0 & lat != 0: cnt[rd] <= min(lat, MAX_LAT). This write overrides the decrement for that register in the same cycle.
- Lat 0 or rd = x0: no entry is created.
- Timing: a producer fires at cycle t with lat L >= 1 -> a dependent first fires at t+L+1. L=1 gives one bubble, which is the classic load-use case. L=0 gives back-to-back issue with no stall.
- last_valid <= issue_fire_o & rd_we & rd != 0 & lat != 0; last_rd <= issue_rd_i. Both are updated every cycle.
- flush_i: when last_valid is set, cnt[last_rd] <= 0. flush_i also suppresses any fire this cycle and forces last_valid <= 0. Because of the WAW rule, the cleared entry belongs only to the squashed instruction.
- flush_i and stall in the same cycle: flush wins. issue_fire_o = 0, and the stall still counts if issue_valid_i is high.
- stall_count_o increments when issue_stall_o = 1. It holds at all-ones.
- pending_mask_o is registered, bit 0 is always 0, and it reflects the post-edge counters.
- Out-of-range indices (>= NUM_REGS) are treated as x0.

Decomposition:
- Package hazard_pkg holds:
  - MAX_LAT default and CNT_W derivation
  - latency constants: LAT_ALU=0, LAT_LOAD=1, LAT_MUL=3, LAT_DIV=MAX_LAT
  - reg-index width
- Sub-module sb_counter holds one per-register CNT_W down-counter with load, clear and decrement. It is instantiated NUM_REGS-1 times in a generate loop.

Test Plan:
- Load-use: fire rd=5 lat=1 at t, then a dependent reading x5 at t+1 -> stall=1 at t+1, fire at t+2, stall_count=1.
- ALU chain: fire rd=3 lat=0, then a reader of x3 next cycle -> no stall, pending_mask bit 3 stays 0.
- Mul latency: fire rd=7 lat=3, reader waits -> stalls at t+1..t+3, fires at t+4, pending_mask bit 7 high for cycles t+1..t+3.
- WAW, x0 and clamp: rd=9 lat=4 pending, then a new writer of x9 (no source use) -> stalled until cnt[9]=0. rd=0 lat=4 -> never pending. lat=7 with MAX_LAT=4 -> counter loads 4.
- Flush: fire rd=12 lat=3 at t, flush_i at t+1 with issue_valid_i high -> cnt[12]=0 at t+2, no fire at t+1, a reader of x12 fires at t+2.
- Reset mid-op: counters nonzero and stall_count=5, assert rst low between edges -> mask and stall_count read 0 asynchronously, and the next reader fires without stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the issue-hazard scoreboard: register index width,
// the default maximum result latency and the latencies of the standard
// execution units.
package hazard_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int REG_IDX_W    = 5;
  localparam int MAX_LAT_DEF  = 4;
  localparam int CNT_W_DEF    = $clog2(MAX_LAT_DEF + 1);

  // Result latency per execution unit (0 = forwarded from the ALU path)
  localparam logic [CNT_W_DEF-1:0] LAT_ALU  = CNT_W_DEF'(0);
  localparam logic [CNT_W_DEF-1:0] LAT_LOAD = CNT_W_DEF'(1);
  localparam logic [CNT_W_DEF-1:0] LAT_MUL  = CNT_W_DEF'(3);
  localparam logic [CNT_W_DEF-1:0] LAT_DIV  = CNT_W_DEF'(MAX_LAT_DEF);

endpackage

// File: rtl/sb_counter.sv
// One scoreboard entry: a countdown of cycles until the register's pending
// result becomes forwardable. Clear (squash) beats load, load beats the
// free-running decrement, and the count never wraps below zero.
module sb_counter
  import hazard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             clear_i,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;

  // Next count: squash, new producer, or one step closer to ready
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count and its registered nonzero flag, dropped at once on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-hazard controller between Decode and Execute. Tracks, per register,
// how many cycles remain until its in-flight result can be forwarded, and
// stalls issue on RAW and WAW hazards against those entries. A taken branch
// squashes the entry created by the instruction issued one cycle earlier.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int REG_ADDR_W = REG_IDX_W,
  parameter int MAX_LAT    = MAX_LAT_DEF,
  parameter int CNT_W      = $clog2(MAX_LAT + 1),
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rs1_i,
  input  logic                  issue_rs1_used_i,
  input  logic [REG_ADDR_W-1:0] issue_rs2_i,
  input  logic                  issue_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic                  issue_rd_we_i,
  input  logic [CNT_W-1:0]      issue_lat_i,
  input  logic                  flush_i,
  output logic                  issue_stall_o,
  output logic                  issue_fire_o,
  output logic [NUM_REGS-1:0]   pending_mask_o,
  output logic [PERF_W-1:0]     stall_count_o
);

  localparam int IDX_SPAN = 1 << REG_ADDR_W;

  // x0 and indices beyond the register file never own an entry
  function automatic logic tracked(input logic [REG_ADDR_W-1:0] idx);
    return (idx != '0) && (int'(idx) < NUM_REGS);
  endfunction

  logic [NUM_REGS-1:0]   busy;
  logic [IDX_SPAN-1:0]   busy_span;
  logic                  src_haz, waw_haz, alloc;
  logic [CNT_W-1:0]      lat_clamped;
  logic                  last_valid_q, last_valid_d;
  logic [REG_ADDR_W-1:0] last_rd_q, last_rd_d;
  logic [PERF_W-1:0]     stall_cnt_q, stall_cnt_d;

  assign busy[0]   = 1'b0;
  assign busy_span = IDX_SPAN'(busy);

  // Hazard detection on pre-edge entries, then the issue handshake
  always_comb begin
    src_haz = (issue_rs1_used_i && tracked(issue_rs1_i) && busy_span[issue_rs1_i]) ||
              (issue_rs2_used_i && tracked(issue_rs2_i) && busy_span[issue_rs2_i]);
    waw_haz = issue_rd_we_i && tracked(issue_rd_i) && busy_span[issue_rd_i];
    issue_stall_o = issue_valid_i && (src_haz || waw_haz);
    issue_fire_o  = issue_valid_i && !issue_stall_o && !flush_i;
    lat_clamped   = (int'(issue_lat_i) > MAX_LAT) ? CNT_W'(MAX_LAT) : issue_lat_i;
    alloc         = issue_fire_o && issue_rd_we_i && tracked(issue_rd_i) &&
                    (issue_lat_i != CNT_W'(LAT_ALU));
  end

  // One countdown per tracked register; x0 has none
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .load_i    (alloc && (issue_rd_i == REG_ADDR_W'(r))),
      .load_val_i(lat_clamped),
      .clear_i   (flush_i && last_valid_q && (last_rd_q == REG_ADDR_W'(r))),
      .busy_o    (busy[r])
    );
  end

  // Remember the entry just created so a flush next cycle can squash it
  always_comb begin
    last_valid_d = alloc;
    last_rd_d    = issue_rd_i;
    stall_cnt_d  = stall_cnt_q;
    if (issue_stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  // Squash tracking and the saturating stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_valid_q <= 1'b0;
      last_rd_q    <= '0;
      stall_cnt_q  <= '0;
    end else begin
      last_valid_q <= last_valid_d;
      last_rd_q    <= last_rd_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign pending_mask_o = busy;
  assign stall_count_o  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus a random
// phase, checked against a behavioural scoreboard model.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NR = 32;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          issue_valid_i = 1'b0;
  logic [4:0]    issue_rs1_i = '0;
  logic          issue_rs1_used_i = 1'b0;
  logic [4:0]    issue_rs2_i = '0;
  logic          issue_rs2_used_i = 1'b0;
  logic [4:0]    issue_rd_i = '0;
  logic          issue_rd_we_i = 1'b0;
  logic [2:0]    issue_lat_i = '0;
  logic          flush_i = 1'b0;
  logic          issue_stall_o;
  logic          issue_fire_o;
  logic [NR-1:0] pending_mask_o;
  logic [PW-1:0] stall_count_o;

  hazard_scoreboard #(
    .PERF_W(PW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid_i   (issue_valid_i),
    .issue_rs1_i     (issue_rs1_i),
    .issue_rs1_used_i(issue_rs1_used_i),
    .issue_rs2_i     (issue_rs2_i),
    .issue_rs2_used_i(issue_rs2_used_i),
    .issue_rd_i      (issue_rd_i),
    .issue_rd_we_i   (issue_rd_we_i),
    .issue_lat_i     (issue_lat_i),
    .flush_i         (flush_i),
    .issue_stall_o   (issue_stall_o),
    .issue_fire_o    (issue_fire_o),
    .pending_mask_o  (pending_mask_o),
    .stall_count_o   (stall_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          stall;
    bit          fire;
    logic [31:0] mask;
    logic [63:0] sc;
  } exp_t;

  exp_t sbq[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_cnt[NR];
  bit m_lv;
  int m_lrd;
  int m_sc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit trk(input int r);
    return (r > 0) && (r < NR);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NR; r++) m_cnt[r] = 0;
    m_lv  = 1'b0;
    m_lrd = 0;
    m_sc  = 0;
  endtask

  // Assert reset between edges and check the outputs clear asynchronously
  task automatic do_reset();
    rst = 1'b0;
    issue_valid_i = 1'b0;
    flush_i = 1'b0;
    #1;
    chk("rst_mask", 64'(pending_mask_o), 64'd0);
    chk("rst_count", 64'(stall_count_o), 64'd0);
    model_clear();
    #1;
    rst = 1'b1;
  endtask

  // Drive one cycle of stimulus, predict, check comb then registered outputs
  task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit we, input int lat, input bit fl);
    exp_t e;
    int   n[NR];
    bit   src, waw, alloc;
    issue_valid_i    = v;
    issue_rs1_i      = rs1[4:0];
    issue_rs1_used_i = u1;
    issue_rs2_i      = rs2[4:0];
    issue_rs2_used_i = u2;
    issue_rd_i       = rd[4:0];
    issue_rd_we_i    = we;
    issue_lat_i      = lat[2:0];
    flush_i          = fl;

    src = (u1 && trk(rs1) && m_cnt[rs1] != 0) || (u2 && trk(rs2) && m_cnt[rs2] != 0);
    waw = we && trk(rd) && m_cnt[rd] != 0;
    e.stall = v && (src || waw);
    e.fire  = v && !e.stall && !fl;
    for (int r = 0; r < NR; r++) n[r] = (m_cnt[r] > 0) ? m_cnt[r] - 1 : 0;
    if (fl && m_lv) n[m_lrd] = 0;
    alloc = e.fire && we && trk(rd) && (lat != 0);
    if (alloc) n[rd] = (lat > 4) ? 4 : lat;
    m_lv  = alloc;
    m_lrd = rd;
    if (e.stall && m_sc < (1 << PW) - 1) m_sc++;
    e.mask = '0;
    for (int r = 1; r < NR; r++) e.mask[r] = (n[r] != 0);
    for (int r = 0; r < NR; r++) m_cnt[r] = n[r];
    e.sc = 64'(m_sc);
    sbq.push_back(e);

    #1;
    chk("stall", 64'(issue_stall_o), 64'(sbq[0].stall));
    chk("fire", 64'(issue_fire_o), 64'(sbq[0].fire));
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("mask", 64'(pending_mask_o), 64'(e.mask));
    chk("count", 64'(stall_count_o), e.sc);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    @(negedge clk);

    // Load-use: one bubble
    do_reset();
    step(1, 0, 0, 0, 0, 5, 1, int'(LAT_LOAD), 0);
    step(1, 5, 1, 0, 0, 6, 1, 0, 0);
    step(1, 5, 1, 0, 0, 6, 1, 0, 0);
    chk("lu_count", 64'(stall_count_o), 64'd1);

    // ALU chain: back-to-back, never pending
    do_reset();
    step(1, 0, 0, 0, 0, 3, 1, int'(LAT_ALU), 0);
    step(1, 3, 1, 3, 1, 4, 1, 0, 0);
    chk("alu_mask3", 64'(pending_mask_o[3]), 64'd0);
    chk("alu_count", 64'(stall_count_o), 64'd0);

    // Multiplier latency: three bubbles
    do_reset();
    step(1, 0, 0, 0, 0, 7, 1, int'(LAT_MUL), 0);
    repeat (4) step(1, 0, 0, 7, 1, 8, 0, 0, 0);
    chk("mul_count", 64'(stall_count_o), 64'd3);

    // WAW, x0 and clamp
    do_reset();
    step(1, 0, 0, 0, 0, 9, 1, int'(LAT_DIV), 0);
    repeat (5) step(1, 0, 0, 0, 0, 9, 1, 2, 0);
    chk("waw_count", 64'(stall_count_o), 64'd4);
    step(1, 0, 0, 0, 0, 0, 1, 4, 0);
    chk("x0_mask0", 64'(pending_mask_o[0]), 64'd0);
    step(1, 0, 0, 0, 0, 10, 1, 7, 0);
    repeat (3) idle();
    chk("clamp_hi", 64'(pending_mask_o[10]), 64'd1);
    idle();
    chk("clamp_lo", 64'(pending_mask_o[10]), 64'd0);

    // Flush squashes the entry of the previous-cycle issue
    do_reset();
    step(1, 0, 0, 0, 0, 12, 1, 3, 0);
    step(1, 12, 1, 0, 0, 13, 1, 1, 1);
    step(1, 12, 1, 0, 0, 13, 1, 0, 0);
    chk("flush_count", 64'(stall_count_o), 64'd1);

    // Reset in the middle of pending work
    do_reset();
    step(1, 0, 0, 0, 0, 20, 1, 4, 0);
    repeat (5) step(1, 20, 1, 0, 0, 21, 1, 4, 0);
    step(1, 21, 1, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_count", 64'(stall_count_o), 64'd5);
    do_reset();
    step(1, 21, 1, 20, 1, 0, 0, 0, 0);

    // Stall counter saturation
    do_reset();
    repeat (5) begin
      step(1, 0, 0, 0, 0, 2, 1, 4, 0);
      repeat (5) step(1, 2, 1, 0, 0, 0, 0, 0, 0);
    end
    chk("sat_count", 64'(stall_count_o), 64'd15);

    // Random traffic over a small register window
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
           int'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
           int'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
           int'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
